// File: rtl/sr_pkg.sv
// Shared encodings and defaults for the SR command sequencer and its helpers.
package sr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK
  } state_e;

  localparam int DEFAULT_PULSE_LEN = 1;
  localparam int DEFAULT_TIMEOUT   = 8;

  // Level the flip-flop should settle to once the command has been applied.
  function automatic logic op_target(input op_e op, input logic q);
    logic t;
    t = q;
    unique case (op)
      OP_SET:    t = 1'b1;
      OP_CLEAR:  t = 1'b0;
      OP_TOGGLE: t = ~q;
      OP_HOLD:   t = q;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns SET/CLEAR/TOGGLE/HOLD commands into legal s/r pulses for the SR stage
// and confirms each one against q_fb within a bounded window.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int PULSE_LEN = DEFAULT_PULSE_LEN,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN);
  localparam logic [7:0] TMO_INIT   = 8'(TIMEOUT);

  state_e     state, state_n;
  logic [3:0] pulse_cnt, pulse_n;
  logic [7:0] tmo_cnt, tmo_n;
  logic       target, target_n;
  logic       hold_op, hold_n;
  logic       s_n, r_n, done_n, err_n;
  logic       err_sat;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pulse_cnt <= '0;
      tmo_cnt   <= '0;
      target    <= 1'b0;
      hold_op   <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      pulse_cnt <= pulse_n;
      tmo_cnt   <= tmo_n;
      target    <= target_n;
      hold_op   <= hold_n;
      s         <= s_n;
      r         <= r_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // s and r are derived from a single target bit, so both can never be high together.
  always_comb begin
    state_n  = state;
    pulse_n  = pulse_cnt;
    tmo_n    = tmo_cnt;
    target_n = target;
    hold_n   = hold_op;
    s_n      = 1'b0;
    r_n      = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n  = ST_DRIVE;
          pulse_n  = PULSE_INIT;
          target_n = op_target(op_e'(cmd_op), q_fb);
          hold_n   = (op_e'(cmd_op) == OP_HOLD);
          s_n      = !hold_n && target_n;
          r_n      = !hold_n && !target_n;
        end
      end
      ST_DRIVE: begin
        if (pulse_cnt <= 4'd1) begin
          state_n = ST_CHECK;
          tmo_n   = TMO_INIT;
        end else begin
          pulse_n = pulse_cnt - 4'd1;
          s_n     = !hold_op && target;
          r_n     = !hold_op && !target;
        end
      end
      ST_CHECK: begin
        if (q_fb == target) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (tmo_cnt == 8'd0) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo_cnt - 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_n && !err_sat),
    .count(err_count),
    .sat  (err_sat)
  );

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Drives random and directed commands into sr_cmd_sequencer against an ideal SR
// stage (or a forced q_fb) and predicts pulse widths and done/err timing.
module tb_sr_cmd_sequencer;

  localparam int PL = 3;
  localparam int TO = 6;
  localparam int EW = 2;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] CLEAR  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          s;
  logic          r;
  logic          q_fb;
  logic          busy;
  logic          done;
  logic          err;
  logic [EW-1:0] err_count;

  logic q_stage;
  logic fb_force;
  logic fb_val;

  int total;
  int bad;
  int err_model;

  sr_cmd_sequencer #(
    .PULSE_LEN(PL),
    .TIMEOUT  (TO),
    .ERR_W    (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .s        (s),
    .r        (r),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal SR flip-flop fed by the sequencer, with an override to emulate a stuck or slow stage.
  always @(posedge clk or posedge rst) begin
    if (rst) q_stage <= 1'b0;
    else if (s) q_stage <= 1'b1;
    else if (r) q_stage <= 1'b0;
  end

  assign q_fb = fb_force ? fb_val : q_stage;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command; forced mode holds q_fb at ~target until check cycle j, never if j > TO.
  task automatic run_cmd(input logic [1:0] op, input bit forced, input bit v0,
                         input int j, input bit keep_valid);
    int  end_k;
    int  budget;
    bit  tgt;
    bit  q_now;
    bit  timeout;
    budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check_output("ready_wait", 32'(cmd_ready), 32'(1));
    if (forced) begin
      fb_force = 1'b1;
      fb_val   = v0;
    end
    q_now = forced ? v0 : q_stage;
    case (op)
      SET:     tgt = 1'b1;
      CLEAR:   tgt = 1'b0;
      TOGGLE:  tgt = !q_now;
      default: tgt = q_now;
    endcase
    timeout = forced && (j > TO);
    end_k   = timeout ? PL + TO + 1 : PL + 1 + (forced ? j : 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      if (!keep_valid) cmd_valid = 1'b0;
      check_output("s", 32'(s), 32'((k < PL) && (op != HOLD) && tgt));
      check_output("r", 32'(r), 32'((k < PL) && (op != HOLD) && !tgt));
      check_output("s_and_r", 32'(s & r), 32'(0));
      check_output("done", 32'(done), 32'((k == end_k) && !timeout));
      check_output("err", 32'(err), 32'((k == end_k) && timeout));
      check_output("busy", 32'(busy), 32'(k < end_k));
      check_output("cmd_ready", 32'(cmd_ready), 32'(k == end_k));
      if (forced) fb_val = (k >= PL + j) ? tgt : !tgt;
    end
    if (timeout && err_model < (1 << EW) - 1) err_model++;
    check_output("err_count", 32'(err_count), 32'(err_model));
    if (!forced) check_output("q_after", 32'(q_fb), 32'(tgt));
    fb_force = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    err_model = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = HOLD;
    fb_force  = 1'b0;
    fb_val    = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_s", 32'(s), 32'(0));
    check_output("rst_r", 32'(r), 32'(0));
    check_output("rst_done", 32'(done), 32'(0));
    check_output("rst_err", 32'(err), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_ready", 32'(cmd_ready), 32'(0));
    check_output("rst_err_count", 32'(err_count), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", 32'(cmd_ready), 32'(1));

    run_cmd(SET, 1'b0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 4; n++) run_cmd(TOGGLE, 1'b0, 1'b0, 0, n < 3);
    run_cmd(CLEAR, 1'b0, 1'b0, 0, 1'b0);

    // Stuck-at-0 feedback: five timeouts walk the 2-bit counter into saturation.
    for (int n = 0; n < 5; n++) run_cmd(SET, 1'b1, 1'b0, TO + 1, 1'b0);
    run_cmd(SET, 1'b1, 1'b0, TO, 1'b0);
    run_cmd(CLEAR, 1'b1, 1'b1, 0, 1'b0);
    run_cmd(HOLD, 1'b1, 1'b1, 2, 1'b0);

    cmd_valid = 1'b1;
    cmd_op    = SET;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("abort_s_drive", 32'(s), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    err_model = 0;
    check_output("abort_s", 32'(s), 32'(0));
    check_output("abort_r", 32'(r), 32'(0));
    check_output("abort_busy", 32'(busy), 32'(0));
    check_output("abort_ready", 32'(cmd_ready), 32'(0));
    check_output("abort_err_count", 32'(err_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_output("post_abort_done", 32'(done), 32'(0));
      check_output("post_abort_err", 32'(err), 32'(0));
      check_output("post_abort_ready", 32'(cmd_ready), 32'(1));
    end
    run_cmd(HOLD, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      bit         forced;
      bit         v0;
      int         j;
      op     = 2'($urandom_range(3));
      forced = ($urandom_range(2) == 0);
      v0     = 1'($urandom_range(1));
      j      = int'($urandom_range(TO + 1));
      repeat ($urandom_range(2)) @(negedge clk);
      run_cmd(op, forced, v0, j, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
